// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and load results onto the regfile write port,
// steering R15 writes to the PC port. Optional macro WB_ROUND_ROBIN_EN.
module wb_arbiter #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [AW-1:0] alu_wa,
  input  logic [DW-1:0] alu_wd,
  input  logic          mem_valid,
  output logic          mem_ready,
  input  logic [AW-1:0] mem_wa,
  input  logic [DW-1:0] mem_wd,
  output logic          we3,
  output logic [AW-1:0] wa3,
  output logic [DW-1:0] wd3,
  output logic          pc_we,
  output logic [DW-1:0] pc_wd,
  output logic          busy
);

  localparam logic [AW-1:0] PC_ADDR = '1;

  logic          full_alu, full_mem;
  logic [AW-1:0] wa_alu, wa_mem;
  logic [DW-1:0] wd_alu, wd_mem;
  logic          older_mem_q;
  logic          grant_alu, grant_mem;
  logic          mem_wins_conflict;
  logic          accept_alu, accept_mem;
  logic          keep_alu, keep_mem;
  logic          any_grant, to_pc;
  logic [AW-1:0] sel_wa;
  logic [DW-1:0] sel_wd;

`ifdef WB_ROUND_ROBIN_EN
  // Set when alu won the most recent contended grant; mem takes the next one.
  logic last_alu_q;
  assign mem_wins_conflict = last_alu_q;
`else
  assign mem_wins_conflict = 1'b1;
`endif

  // Grant looks only at slot state, so ready never depends on valid.
  always_comb begin
    // NOTE: default every always_comb output first so no path can infer a latch.
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (full_alu && full_mem) begin
      grant_mem = (wa_alu == wa_mem) ? older_mem_q : mem_wins_conflict;
      grant_alu = ~grant_mem;
    end else begin
      grant_alu = full_alu;
      grant_mem = full_mem;
    end
  end

  assign alu_ready  = ~reset & (~full_alu | grant_alu);
  assign mem_ready  = ~reset & (~full_mem | grant_mem);
  assign accept_alu = alu_valid & alu_ready;
  assign accept_mem = mem_valid & mem_ready;
  assign keep_alu   = full_alu & ~grant_alu;
  assign keep_mem   = full_mem & ~grant_mem;

  assign any_grant = grant_alu | grant_mem;
  assign sel_wa    = grant_mem ? wa_mem : wa_alu;
  assign sel_wd    = grant_mem ? wd_mem : wd_alu;
  assign to_pc     = any_grant & (sel_wa == PC_ADDR);

  assign we3   = any_grant & ~to_pc;
  assign wa3   = we3 ? sel_wa : '0;
  assign wd3   = we3 ? sel_wd : '0;
  assign pc_we = to_pc;
  assign pc_wd = to_pc ? sel_wd : '0;
  assign busy  = full_alu | full_mem;

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_alu    <= 1'b0;
      full_mem    <= 1'b0;
      older_mem_q <= 1'b1;
    end else begin
      full_alu    <= accept_alu | keep_alu;
      full_mem    <= accept_mem | keep_mem;
      // A slot that stays put is older than one refilled this edge; a tie favours mem.
      older_mem_q <= ~keep_alu | keep_mem;
    end
  end

`ifdef WB_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_alu_q <= 1'b1;
    end else if (full_alu && full_mem) begin
      last_alu_q <= grant_alu;
    end
  end
`endif

  // NOTE: payload registers carry no reset; they are only observed behind a full bit.
  always_ff @(posedge clk) begin
    if (accept_alu) begin
      wa_alu <= alu_wa;
      wd_alu <= alu_wd;
    end
    if (accept_mem) begin
      wa_mem <= mem_wa;
      wd_mem <= mem_wd;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed vector table, corner sequences,
// and randomized traffic against a timestamp-based slot model.
module tb_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          alu_valid, mem_valid;
  logic          alu_ready, mem_ready;
  logic [AW-1:0] alu_wa, mem_wa;
  logic [DW-1:0] alu_wd, mem_wd;
  logic          we3, pc_we, busy;
  logic [AW-1:0] wa3;
  logic [DW-1:0] wd3, pc_wd;

  wb_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_wa(alu_wa), .alu_wd(alu_wd),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wa(mem_wa), .mem_wd(mem_wd),
    .we3(we3), .wa3(wa3), .wd3(wd3), .pc_we(pc_we), .pc_wd(pc_wd), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef logic [72:0] obs_t;  // {we3, wa3, wd3, pc_we, pc_wd, busy, alu_ready, mem_ready}

  typedef struct {
    bit          rst;
    bit          av;
    logic [3:0]  awa;
    logic [31:0] awd;
    bit          mv;
    logic [3:0]  mwa;
    logic [31:0] mwd;
    obs_t        exp;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: index 0 = alu, 1 = mem; stamp = cycle the entry arrived.
  bit          m_full[2];
  logic [3:0]  m_wa[2];
  logic [31:0] m_wd[2];
  int          m_stamp[2];
  bit          m_last_alu;
  int          cyc = 0;

  function automatic obs_t mk(bit we, logic [3:0] wa, logic [31:0] wd, bit pwe,
                              logic [31:0] pwd, bit bsy, bit ar, bit mr);
    return {we, wa, wd, pwe, pwd, bsy, ar, mr};
  endfunction

  function automatic obs_t actual();
    return {we3, wa3, wd3, pc_we, pc_wd, busy, alu_ready, mem_ready};
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic add(input bit rst, input bit av, input logic [3:0] awa, input logic [31:0] awd,
                     input bit mv, input logic [3:0] mwa, input logic [31:0] mwd, input obs_t exp);
    vec_t v;
    v.rst = rst; v.av = av; v.awa = awa; v.awd = awd;
    v.mv = mv; v.mwa = mwa; v.mwd = mwd; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic model_clear();
    m_full[0] = 0; m_full[1] = 0;
    m_last_alu = 1;
  endtask

  // Winner: -1 none, 0 alu, 1 mem.
  function automatic int model_grant();
    if (m_full[0] && m_full[1]) begin
      if (m_wa[0] == m_wa[1]) return (m_stamp[1] <= m_stamp[0]) ? 1 : 0;
`ifdef WB_ROUND_ROBIN_EN
      return m_last_alu ? 1 : 0;
`else
      return 1;
`endif
    end
    if (m_full[1]) return 1;
    if (m_full[0]) return 0;
    return -1;
  endfunction

  function automatic obs_t model_expect();
    int g = model_grant();
    bit ar = !reset && (!m_full[0] || g == 0);
    bit mr = !reset && (!m_full[1] || g == 1);
    bit bsy = m_full[0] || m_full[1];
    if (g < 0) return mk(0, 0, 0, 0, 0, bsy, ar, mr);
    if (m_wa[g] == 4'hF) return mk(0, 0, 0, 1, m_wd[g], bsy, ar, mr);
    return mk(1, m_wa[g], m_wd[g], 0, 0, bsy, ar, mr);
  endfunction

  task automatic model_edge();
    int g;
    bit ar, mr;
    if (reset) begin
      model_clear();
    end else begin
      g  = model_grant();
      ar = !m_full[0] || g == 0;
      mr = !m_full[1] || g == 1;
      if (m_full[0] && m_full[1]) m_last_alu = (g == 0);
      if (g >= 0) m_full[g] = 0;
      if (alu_valid && ar) begin
        m_full[0] = 1; m_wa[0] = alu_wa; m_wd[0] = alu_wd; m_stamp[0] = cyc;
      end
      if (mem_valid && mr) begin
        m_full[1] = 1; m_wa[1] = mem_wa; m_wd[1] = mem_wd; m_stamp[1] = cyc;
      end
    end
    cyc++;
  endtask

  task automatic drive(input bit rst, input bit av, input logic [3:0] awa, input logic [31:0] awd,
                       input bit mv, input logic [3:0] mwa, input logic [31:0] mwd);
    reset = rst;
    if (rst) model_clear();
    alu_valid = av; alu_wa = awa; alu_wd = awd;
    mem_valid = mv; mem_wa = mwa; mem_wd = mwd;
  endtask

  // Observe at the falling edge, advance the model, then step past the rising edge.
  task automatic tick(input string name, output obs_t seen);
    @(negedge clk);
    seen = actual();
    check(name, seen, model_expect());
    model_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    obs_t seen;
    int   alu_writes;
    logic [3:0] wsel;

    // Directed vectors, one row per cycle; outputs are those seen before the edge.
    add(1, 0, 0, 0,        0, 0, 0,        mk(0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 1, 3, 32'h1234, 0, 0, 0,        mk(0, 0, 0, 0, 0, 0, 1, 1));
    add(0, 0, 0, 0,        0, 0, 0,        mk(1, 3, 32'h1234, 0, 0, 1, 1, 1));
    add(0, 0, 0, 0,        0, 0, 0,        mk(0, 0, 0, 0, 0, 0, 1, 1));
    add(0, 1, 2, 32'hAA,   1, 5, 32'hBB,   mk(0, 0, 0, 0, 0, 0, 1, 1));
    add(0, 0, 0, 0,        0, 0, 0,        mk(1, 5, 32'hBB, 0, 0, 1, 0, 1));
    add(0, 0, 0, 0,        0, 0, 0,        mk(1, 2, 32'hAA, 0, 0, 1, 1, 1));
    add(0, 0, 0, 0,        0, 0, 0,        mk(0, 0, 0, 0, 0, 0, 1, 1));
    add(1, 0, 0, 0,        0, 0, 0,        mk(0, 0, 0, 0, 0, 0, 0, 0));
    add(0, 0, 0, 0,        1, 4, 32'h11,   mk(0, 0, 0, 0, 0, 0, 1, 1));
    add(0, 1, 4, 32'h22,   0, 0, 0,        mk(1, 4, 32'h11, 0, 0, 1, 1, 1));
    add(0, 0, 0, 0,        0, 0, 0,        mk(1, 4, 32'h22, 0, 0, 1, 1, 1));
    add(0, 1, 4, 32'h22,   1, 5, 32'h33,   mk(0, 0, 0, 0, 0, 0, 1, 1));
    add(0, 0, 0, 0,        1, 4, 32'h11,   mk(1, 5, 32'h33, 0, 0, 1, 0, 1));
    add(0, 0, 0, 0,        0, 0, 0,        mk(1, 4, 32'h22, 0, 0, 1, 1, 0));
    add(0, 0, 0, 0,        0, 0, 0,        mk(1, 4, 32'h11, 0, 0, 1, 1, 1));
    add(0, 0, 0, 0,        1, 4'hF, 32'h100, mk(0, 0, 0, 0, 0, 0, 1, 1));
    add(0, 0, 0, 0,        0, 0, 0,        mk(0, 0, 0, 1, 32'h100, 1, 1, 1));
    add(0, 0, 0, 0,        0, 0, 0,        mk(0, 0, 0, 0, 0, 0, 1, 1));

    drive(1, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].av, tbl[i].awa, tbl[i].awd, tbl[i].mv, tbl[i].mwa, tbl[i].mwd);
      @(negedge clk);
      check($sformatf("table_row%0d", i), actual(), tbl[i].exp);
      check($sformatf("table_model%0d", i), actual(), model_expect());
      model_edge();
      @(posedge clk);
      #1;
    end

    // Continuous contention: alu is starved under fixed priority, alternates under round-robin.
    drive(1, 0, 0, 0, 0, 0, 0);
    tick("starve_reset", seen);
    alu_writes = 0;
    for (int c = 0; c < 7; c++) begin
      drive(0, 1, 1, 32'hA000 + c, 1, 2, 32'hB000 + c);
      tick($sformatf("starve_c%0d", c), seen);
      if (c > 0 && seen[72] && seen[71:68] == 4'd1) alu_writes++;
    end
`ifdef WB_ROUND_ROBIN_EN
    check("alu_grant_count", obs_t'(alu_writes), obs_t'(3));
`else
    check("alu_grant_count", obs_t'(alu_writes), obs_t'(0));
`endif

    // Asynchronous reset with both slots full: outputs drop before any edge.
    drive(0, 1, 6, 32'hC0, 1, 4'hF, 32'hC1);
    tick("prefill", seen);
    #1;
    drive(1, 0, 0, 0, 0, 0, 0);
    #1;
    check("async_reset_outputs", actual(), mk(0, 0, 0, 0, 0, 0, 0, 0));
    tick("reset_hold", seen);
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      tick($sformatf("post_reset%0d", c), seen);
      check($sformatf("no_stale_write%0d", c), obs_t'({we3, pc_we, busy}), obs_t'(0));
    end

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      wsel = 4'($urandom_range(0, 3));
      drive($urandom_range(0, 49) == 0,
            $urandom_range(0, 9) < 7, (wsel == 3) ? 4'hF : wsel + 4'd1, $urandom,
            $urandom_range(0, 9) < 7, 4'($urandom_range(1, 3)) | {4{$urandom_range(0, 7) == 0}},
            $urandom);
      tick("random", seen);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
